// File: rtl/inhib_ctrl_h1_pkg.sv
// Shared sizing defaults and FSM encoding for the inhibition-unit controller.
package inhib_ctrl_h1_pkg;

  localparam int W_DEF  = 24;
  localparam int N3_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTEG = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_APPLY = 3'd4
  } state_t;

endpackage

// File: rtl/inhib_ctrl_h1_sat_acc.sv
// sat_acc: one neuron's signed saturating add, clamping to [0, 2^W-1].
module inhib_ctrl_h1_sat_acc #(
  parameter int W = 24
) (
  input  logic        [W-1:0] pot,
  input  logic signed [W-1:0] delta,
  output logic        [W-1:0] result
);

  logic signed [W+1:0] ext;

  always_comb begin
    ext = $signed({2'b00, pot}) + $signed({{2{delta[W-1]}}, delta});
    if (ext[W+1])
      result = '0;
    else if (ext[W])
      result = '1;
    else
      result = ext[W-1:0];
  end

endmodule

// File: rtl/inhib_ctrl_h1.sv
// Timestep controller: integrates deltas into membrane potentials, handshakes with
// the lateral-inhibition unit, then applies winner reset or leak with refractory gating.
// state | meaning
// IDLE  | accepts a delta vector; refractory timesteps are discarded here
// INTEG | saturating add of the latched deltas
// REQ   | start_li pulse to the inhibition unit
// WAIT  | waiting for valid_li, bounded by LI_TIMEOUT
// APPLY | winner reset or leak; step_done and spike_out registered
module inhib_ctrl_h1
  import inhib_ctrl_h1_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int N3         = N3_DEF,
  parameter int LEAK       = 1,
  parameter int REFRACT_T  = 4,
  parameter int LI_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N3*W-1:0] deltas,
  output logic [N3*W-1:0] potentials,
  output logic            start_li,
  input  logic [N3-1:0]   won_lost,
  input  logic            valid_li,
  input  logic            first_spike,
  output logic [N3-1:0]   spike_out,
  output logic            step_done,
  output logic            li_err
);

  localparam int RC = (REFRACT_T > 0) ? $clog2(REFRACT_T + 1) : 1;
  localparam int WC = $clog2(LI_TIMEOUT + 1);
  localparam logic [RC-1:0] REFR_LOAD = RC'(REFRACT_T);
  localparam logic [WC-1:0] WAIT_LAST = WC'(LI_TIMEOUT - 1);
  localparam logic [W-1:0]  LEAK_W    = W'(LEAK);

  state_t state, state_nxt;

  logic [N3-1:0][W-1:0] pot_q;
  logic [N3-1:0][W-1:0] delta_q;
  logic [N3-1:0][W-1:0] sum_vec;
  logic [RC-1:0]        refr_cnt;
  logic [WC-1:0]        wait_cnt;
  logic [N3-1:0]        wl_q;
  logic                 fs_q;
  logic                 xfer;
  logic                 timeout;
  logic                 wl_onehot;

  assign potentials = pot_q;
  assign xfer       = in_valid && in_ready;
  assign timeout    = (wait_cnt == WAIT_LAST) && !valid_li;
  assign wl_onehot  = (wl_q != '0) && ((wl_q & (wl_q - N3'(1))) == '0);

  for (genvar k = 0; k < N3; k++) begin : g_acc
    inhib_ctrl_h1_sat_acc #(.W(W)) u_sat_acc (
      .pot    (pot_q[k]),
      .delta  (delta_q[k]),
      .result (sum_vec[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_li  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst;
        if (in_valid && rst && refr_cnt == '0)
          state_nxt = S_INTEG;
      end
      S_INTEG: state_nxt = S_REQ;
      S_REQ: begin
        start_li  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (valid_li)
          state_nxt = S_APPLY;
        else if (timeout)
          state_nxt = S_IDLE;
      end
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pot_q     <= '0;
      delta_q   <= '0;
      refr_cnt  <= '0;
      wait_cnt  <= '0;
      wl_q      <= '0;
      fs_q      <= 1'b0;
      spike_out <= '0;
      step_done <= 1'b0;
      li_err    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      spike_out <= '0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (refr_cnt != '0) begin
              refr_cnt  <= refr_cnt - RC'(1);
              step_done <= 1'b1;
            end else begin
              delta_q <= deltas;
            end
          end
        end
        S_INTEG: pot_q <= sum_vec;
        S_REQ:   wait_cnt <= '0;
        S_WAIT: begin
          wait_cnt <= wait_cnt + WC'(1);
          if (valid_li) begin
            wl_q <= won_lost;
            fs_q <= first_spike;
          end else if (timeout) begin
            li_err    <= 1'b1;
            step_done <= 1'b1;
          end
        end
        S_APPLY: begin
          step_done <= 1'b1;
          if (fs_q) begin
            // winner reset and lateral inhibition both clear every neuron
            pot_q     <= '0;
            spike_out <= wl_q & (~wl_q + N3'(1));
            refr_cnt  <= REFR_LOAD;
            if (!wl_onehot)
              li_err <= 1'b1;
          end else begin
            for (int k = 0; k < N3; k++)
              pot_q[k] <= (pot_q[k] >= LEAK_W) ? pot_q[k] - LEAK_W : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inhib_ctrl_h1.sv
// Directed bench for inhib_ctrl_h1 with a timestep-level reference model.
module tb_inhib_ctrl_h1;

  localparam int W = 24;
  localparam int N3 = 3;
  localparam int LEAK = 1;
  localparam int REFRACT_T = 4;
  localparam int LI_TIMEOUT = 16;
  localparam longint PMAX = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [N3*W-1:0] deltas = '0;
  logic [N3*W-1:0] potentials;
  logic start_li;
  logic [N3-1:0] won_lost = '0;
  logic valid_li = 1'b0;
  logic first_spike = 1'b0;
  logic [N3-1:0] spike_out;
  logic step_done;
  logic li_err;

  int checks = 0;
  int errors = 0;

  longint mpot[N3];
  longint mid_pot[N3];
  int mrefr = 0;
  bit merr = 1'b0;

  always #5 clk = ~clk;

  inhib_ctrl_h1 #(
    .W(W), .N3(N3), .LEAK(LEAK), .REFRACT_T(REFRACT_T), .LI_TIMEOUT(LI_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .deltas(deltas), .potentials(potentials), .start_li(start_li),
    .won_lost(won_lost), .valid_li(valid_li), .first_spike(first_spike),
    .spike_out(spike_out), .step_done(step_done), .li_err(li_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic longint pot_of(input int k);
    longint v;
    v = {40'd0, potentials[k*W +: W]};
    return v;
  endfunction

  function automatic longint clampv(input longint v);
    if (v < 0) return 0;
    if (v > PMAX) return PMAX;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N3; k++) mpot[k] = 0;
    mrefr = 0;
    merr = 1'b0;
  endtask

  // lat < 0 means the inhibition unit never answers
  task automatic step(input int d0, input int d1, input int d2, input int lat,
                      input bit fs, input logic [N3-1:0] wl, input string tag);
    int d[N3];
    longint exp_mid[N3];
    logic [N3-1:0] exp_spike;
    logic [31:0] t;
    int exp_k;
    int n;
    bit refr;
    d = '{d0, d1, d2};
    exp_spike = '0;
    refr = (mrefr > 0);
    if (refr) begin
      mrefr--;
      exp_k = 1;
    end else begin
      for (int k = 0; k < N3; k++) mpot[k] = clampv(mpot[k] + longint'(d[k]));
      exp_mid = mpot;
      if (lat < 0) begin
        exp_k = 3 + LI_TIMEOUT;
        merr = 1'b1;
      end else begin
        exp_k = 4 + lat;
        if (fs) begin
          for (int k = 0; k < N3; k++) mpot[k] = 0;
          for (int k = 0; k < N3; k++)
            if (wl[k]) begin exp_spike[k] = 1'b1; break; end
          if ($countones(wl) != 1) merr = 1'b1;
          mrefr = REFRACT_T;
        end else begin
          for (int k = 0; k < N3; k++) mpot[k] = (mpot[k] > LEAK) ? mpot[k] - LEAK : 0;
        end
      end
    end

    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s in_ready_before", tag), in_ready, 1);
    for (int k = 0; k < N3; k++) begin
      t = d[k];
      deltas[k*W +: W] = t[W-1:0];
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;

    for (int c = 1; c <= exp_k; c++) begin
      @(negedge clk);
      chk($sformatf("%s start_li c%0d", tag, c), start_li, (!refr && c == 2) ? 1 : 0);
      chk($sformatf("%s step_done c%0d", tag, c), step_done, (c == exp_k) ? 1 : 0);
      chk($sformatf("%s in_ready c%0d", tag, c), in_ready, (c == exp_k) ? 1 : 0);
      if (c == exp_k) begin
        chk($sformatf("%s spike_out", tag), spike_out, exp_spike);
        chk($sformatf("%s li_err", tag), li_err, merr);
        for (int k = 0; k < N3; k++)
          chk($sformatf("%s pot%0d", tag, k), pot_of(k), mpot[k]);
      end else begin
        chk($sformatf("%s spike_idle c%0d", tag, c), spike_out, 0);
      end
      if (!refr && c >= 2 && c < exp_k)
        for (int k = 0; k < N3; k++)
          chk($sformatf("%s held%0d c%0d", tag, k, c), pot_of(k), exp_mid[k]);
      if (c == 3)
        for (int k = 0; k < N3; k++) mid_pot[k] = pot_of(k);
      valid_li = (!refr && lat >= 0 && c == 2 + lat);
      first_spike = fs;
      won_lost = wl;
    end
    valid_li = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst step_done", step_done, 0);
    chk("rst start_li", start_li, 0);
    chk("rst spike_out", spike_out, 0);
    chk("rst li_err", li_err, 0);
    for (int k = 0; k < N3; k++) chk($sformatf("rst pot%0d", k), pot_of(k), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready", in_ready, 1);

    for (int i = 0; i < 3; i++) step(10, 20, 30, 7, 1'b0, 3'b111, $sformatf("leak%0d", i));
    chk("lit pot0 27", pot_of(0), 27);
    chk("lit pot1 57", pot_of(1), 57);
    chk("lit pot2 87", pot_of(2), 87);

    step(0, 0, 10, 7, 1'b1, 3'b100, "spike");
    chk("lit spike 100", spike_out, 3'b100);
    chk("lit pot2 zero", pot_of(2), 0);
    for (int i = 0; i < REFRACT_T; i++) step(5, 5, 5, 7, 1'b0, 3'b111, $sformatf("refr%0d", i));
    step(5, 5, 5, 7, 1'b0, 3'b111, "post_refr");
    chk("lit post_refr pot0", pot_of(0), 4);

    step(2, 8388607, 0, 7, 1'b0, 3'b111, "big_a");
    step(1, 8388597, 0, 7, 1'b0, 3'b111, "big_b");
    chk("lit pot0 5", pot_of(0), 5);
    chk("lit pot1 2^24-10", pot_of(1), 16777206);
    step(-100, 100, 0, -1, 1'b0, 3'b111, "timeout");
    chk("lit clamp low", mid_pot[0], 0);
    chk("lit clamp high", mid_pot[1], 16777215);
    chk("lit timeout li_err", li_err, 1);
    chk("lit timeout pot2", pot_of(2), 2);

    // reset while waiting on the inhibition unit
    while (!in_ready) @(negedge clk);
    deltas = {24'd1, 24'd1, 24'd1};
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst in_ready", in_ready, 0);
      chk("midrst step_done", step_done, 0);
      chk("midrst start_li", start_li, 0);
      chk("midrst pot1", pot_of(1), 0);
    end
    model_reset();
    rst = 1'b1;
    valid_li = 1'b1;
    first_spike = 1'b1;
    won_lost = 3'b001;
    @(negedge clk);
    valid_li = 1'b0;
    chk("midrst in_ready_back", in_ready, 1);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("midrst quiet step_done c%0d", c), step_done, 0);
      chk($sformatf("midrst quiet spike c%0d", c), spike_out, 0);
      chk($sformatf("midrst quiet li_err c%0d", c), li_err, 0);
      @(negedge clk);
    end

    step(0, 0, 0, 7, 1'b1, 3'b110, "malformed");
    chk("lit malformed spike", spike_out, 3'b010);
    chk("lit malformed li_err", li_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
